bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Single-port memory arbiter between a CPU and a DMA engine.
// The CPU is frozen through cpu_en while the DMA engine owns the bus.
module bus_arbiter #(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned CPU_SLICE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_read,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        cpu_en,
   input  logic        dma_req,
   output logic        dma_gnt,
   input  logic        dma_valid,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic [7:0]  dma_rdata,
   output logic        dma_rvalid,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic [1:0] {
      S_CPU,
      S_HANDOVER,
      S_DMA,
      S_RETURN
   } state_t;

   localparam logic [7:0] SLICE_INIT = 8'(CPU_SLICE);
   localparam logic [7:0] BURST_LEN  = 8'(MAX_BURST);

   state_t      state;
   state_t      state_nx;
   logic [7:0]  slice_cnt;
   logic [7:0]  beat_cnt;
   logic        accept;
   logic        last_beat;
   logic        slice_ok;

   // A beat needs the grant, a live request and no reset in progress.
   assign accept    = !rst && (state == S_DMA) && dma_req && dma_valid;
   assign last_beat = accept && ((beat_cnt + 8'd1) == BURST_LEN);
   // The current CPU cycle counts toward the slice, so exactly CPU_SLICE
   // CPU cycles elapse after a forced release before handing over again.
   assign slice_ok  = ({1'b0, slice_cnt} + 9'd1) >= 9'(CPU_SLICE);
   assign cpu_din   = mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) state <= S_CPU;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cpu_en    = 1'b1;
      dma_gnt   = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_dout;
      mem_we    = ~cpu_read;
      if (!rst) begin
         unique case (state)
            S_CPU: begin
               if (dma_req && slice_ok) state_nx = S_HANDOVER;
            end
            S_HANDOVER: begin
               cpu_en   = 1'b0;
               mem_we   = 1'b0;
               state_nx = S_DMA;
            end
            S_DMA: begin
               cpu_en    = 1'b0;
               dma_gnt   = 1'b1;
               mem_addr  = dma_addr;
               mem_wdata = dma_wdata;
               mem_we    = accept && dma_we;
               if (!dma_req || last_beat) state_nx = S_RETURN;
            end
            S_RETURN: begin
               cpu_en   = 1'b0;
               mem_we   = 1'b0;
               state_nx = S_CPU;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slice_cnt  <= SLICE_INIT;
         beat_cnt   <= '0;
         dma_rvalid <= 1'b0;
         dma_rdata  <= '0;
      end else begin
         dma_rvalid <= accept && !dma_we;
         if (accept && !dma_we) dma_rdata <= mem_rdata;
         unique case (state)
            S_CPU: begin
               if (slice_cnt != 8'hFF) slice_cnt <= slice_cnt + 8'd1;
            end
            S_HANDOVER: beat_cnt <= '0;
            S_DMA: begin
               // Slice is settled on leaving DMA; RETURN leaves it untouched.
               if (!dma_req) begin
                  slice_cnt <= SLICE_INIT;
               end else if (accept) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  if (last_beat) slice_cnt <= '0;
               end
            end
            S_RETURN: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: a per-cycle ownership model feeds a
// scoreboard queue that an independent monitor drains and compares.
module tb_bus_arbiter;

   localparam int MAX_BURST = 16;
   localparam int CPU_SLICE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_read = 1'b1;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_dout = '0;
   logic [7:0]  cpu_din;
   logic        cpu_en;
   logic        dma_req = 1'b0;
   logic        dma_gnt;
   logic        dma_valid = 1'b0;
   logic        dma_we = 1'b0;
   logic [15:0] dma_addr = '0;
   logic [7:0]  dma_wdata = '0;
   logic [7:0]  dma_rdata;
   logic        dma_rvalid;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   bus_arbiter #(.MAX_BURST(MAX_BURST), .CPU_SLICE(CPU_SLICE)) dut (
      .clk(clk), .rst(rst),
      .cpu_read(cpu_read), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .cpu_en(cpu_en),
      .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_valid(dma_valid),
      .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Address-dependent memory contents; 0x0010 reads back 0x3C.
   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h2C;
   endfunction

   assign mem_rdata = mem_f(mem_addr);

   typedef struct {
      logic        cpu_en;
      logic        gnt;
      logic        we;
      logic        rvalid;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  rd_q[$];
   int          errors = 0;
   int          checks = 0;
   bit          done = 1'b0;

   // Reference model: who owns the bus and for how long.
   bit m_dma_owns     = 1'b0;
   bit m_freeze_in    = 1'b0;
   bit m_freeze_out   = 1'b0;
   bit m_rvalid       = 1'b0;
   int m_cpu_owned    = CPU_SLICE;
   int m_beats        = 0;

   task automatic model_cycle();
      exp_t e;
      bit   cpu_view;
      bit   accept;
      cpu_view = rst || !(m_dma_owns || m_freeze_in || m_freeze_out);
      accept   = !rst && m_dma_owns && dma_req && dma_valid;
      e.cpu_en = cpu_view;
      e.gnt    = !rst && m_dma_owns;
      e.rvalid = m_rvalid;
      if (e.gnt) begin
         e.addr = dma_addr;  e.wdata = dma_wdata;  e.we = accept && dma_we;
      end else begin
         e.addr = cpu_addr;  e.wdata = cpu_dout;   e.we = cpu_view && !cpu_read;
      end
      exp_q.push_back(e);
      if (accept && !dma_we) rd_q.push_back(mem_f(dma_addr));

      if (rst) begin
         m_dma_owns = 0; m_freeze_in = 0; m_freeze_out = 0;
         m_rvalid = 0; m_cpu_owned = CPU_SLICE; m_beats = 0;
      end else begin
         m_rvalid = accept && !dma_we;
         if (m_freeze_out) begin
            m_freeze_out = 0;
         end else if (m_freeze_in) begin
            m_freeze_in = 0; m_dma_owns = 1; m_beats = 0;
         end else if (m_dma_owns) begin
            if (!dma_req) begin
               m_dma_owns = 0; m_freeze_out = 1; m_cpu_owned = CPU_SLICE;
            end else if (accept) begin
               m_beats++;
               if (m_beats == MAX_BURST) begin
                  m_dma_owns = 0; m_freeze_out = 1; m_cpu_owned = 0;
               end
            end
         end else begin
            m_cpu_owned++;
            if (dma_req && m_cpu_owned >= CPU_SLICE) m_freeze_in = 1;
         end
      end
   endtask

   task automatic cyc(input bit r, input bit req, input bit v, input bit we,
                      input logic [15:0] da, input logic [7:0] dw,
                      input bit crd, input logic [15:0] ca, input logic [7:0] cd);
      @(negedge clk);
      rst = r; dma_req = req; dma_valid = v; dma_we = we;
      dma_addr = da; dma_wdata = dw; cpu_read = crd; cpu_addr = ca; cpu_dout = cd;
      model_cycle();
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exv);
      checks++;
      if (act !== exv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exv, $time);
      end
   endtask

   // Monitor: samples 2 time units after the falling edge, away from posedge.
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cpu_en", 16'(cpu_en), 16'(e.cpu_en));
            chk("dma_gnt", 16'(dma_gnt), 16'(e.gnt));
            chk("mem_we", 16'(mem_we), 16'(e.we));
            chk("mem_addr", mem_addr, e.addr);
            chk("cpu_din", 16'(cpu_din), 16'(mem_f(e.addr)));
            chk("dma_rvalid", 16'(dma_rvalid), 16'(e.rvalid));
            if (e.we) chk("mem_wdata", 16'(mem_wdata), 16'(e.wdata));
            if (dma_rvalid === 1'b1) begin
               if (rd_q.size() == 0) begin
                  chk("rdata_unexpected", 16'(dma_rvalid), 16'h0);
               end else begin
                  chk("dma_rdata", 16'(dma_rdata), 16'(rd_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      bit req;
      // reset
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 16'h0, 8'h0, 1, 16'h0, 8'h0);
      // idle CPU write
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 16'h0, 8'h0, 0, 16'h1234, 8'h5A);
      // grant, one write beat, one read beat, then burst to forced release
      cyc(0, 1, 0, 0, 16'h0, 8'h0, 1, 16'h2000, 8'h00);
      cyc(0, 1, 0, 0, 16'h0, 8'h0, 1, 16'h2000, 8'h00);
      cyc(0, 1, 1, 1, 16'h8000, 8'hA5, 1, 16'h2000, 8'h00);
      cyc(0, 1, 1, 0, 16'h0010, 8'h00, 1, 16'h2000, 8'h00);
      for (int i = 0; i < 14; i++)
         cyc(0, 1, 1, i[0], 16'h4000 + 16'(i), 8'(i), 1, 16'h2000, 8'h00);
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 16'h0, 8'h0, 0, 16'h3000 + 16'(i), 8'(i));
      // three beats, drop request with valid high, re-request immediately
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 16'h5000 + 16'(i), 8'h11, 1, 16'h0, 8'h0);
      cyc(0, 0, 1, 1, 16'h5003, 8'h22, 1, 16'h0, 8'h0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 16'h0, 8'h0, 0, 16'h6000, 8'h33);
      // reset during beat 5 of a read burst
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 16'h7000 + 16'(i), 8'h0, 1, 16'h0, 8'h0);
      cyc(1, 1, 1, 0, 16'h7004, 8'h0, 0, 16'h0ABC, 8'h44);
      cyc(0, 0, 1, 1, 16'h7005, 8'h55, 0, 16'h0ABC, 8'h44);
      // randomized traffic
      req = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) req = !req;
         cyc($urandom_range(0, 199) == 0, req, $urandom_range(0, 9) < 7,
             1'($urandom), 16'($urandom), 8'($urandom),
             1'($urandom), 16'($urandom), 8'($urandom));
      end
      cyc(0, 0, 0, 0, 16'h0, 8'h0, 1, 16'h0, 8'h0);
      repeat (4) @(negedge clk);
      done = 1'b1;
      #3;
      chk("exp_q_drained", 16'(exp_q.size()), 16'h0);
      chk("rd_q_drained", 16'(rd_q.size()), 16'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
